memory_cycle: RTL and testbench

//  MEM pipeline stage of the 5-stage RV32 core. Holds a SECDED-protected data memory (32b data + 7b check).

---
 rtl/riscv_ecc_pkg.sv | 22 ++
 rtl/secded_codec.sv | 39 +++
 rtl/memory_cycle.sv | 110 +++++++++++
 tb/tb_memory_cycle.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/riscv_ecc_pkg.sv
// riscv_ecc_pkg: SECDED (39,32) widths, Hamming position masks, codeword type and MEM FSM states
package riscv_ecc_pkg;
  localparam int DATA_W = 32;
  localparam int CHK_W = 7;
  localparam int CODE_W = DATA_W + CHK_W;
  localparam int HAM_W = CHK_W - 1;

  typedef logic [CODE_W-1:0] ecc_word_t;
  typedef enum logic {IDLE, SCRUB} mem_state_t;

  // Bit i of a codeword is Hamming position i; bit 0 is the overall parity bit.
  function automatic logic isPow2(input int i);
    return (i & (i - 1)) == 0;
  endfunction

  function automatic ecc_word_t chkMask(input int k);
    ecc_word_t m;
    m = '0;
    for (int i = 1; i < CODE_W; i++) m[i] = i[k];
    return m;
  endfunction
endpackage

// File: rtl/secded_codec.sv
// secded_codec: combinational SECDED encode (data->code) and decode/correct (word->fixData, sbe, dbe)
module secded_codec
  import riscv_ecc_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  ecc_word_t         word,
  output ecc_word_t         code,
  output logic [DATA_W-1:0] fixData,
  output ecc_word_t         fixWord,
  output logic              sbe,
  output logic              dbe
);
  logic [HAM_W-1:0] syn;
  int n;

  always_comb begin
    code = '0;
    n = 0;
    for (int i = 1; i < CODE_W; i++)
      if (!isPow2(i)) begin
        code[i] = data[n];
        n++;
      end
    for (int k = 0; k < HAM_W; k++) code[1 << k] = ^(code & chkMask(k));
    code[0] = ^code;
    for (int k = 0; k < HAM_W; k++) syn[k] = ^(word & chkMask(k));
    // Odd overall parity means one flipped bit; syndrome 0 points at the parity bit itself.
    sbe = ^word;
    dbe = (syn != '0) && !sbe;
    fixWord = sbe ? word ^ (ecc_word_t'(1) << syn) : word;
    fixData = '0;
    n = 0;
    for (int i = 1; i < CODE_W; i++)
      if (!isPow2(i)) begin
        fixData[n] = fixWord[i];
        n++;
      end
  end
endmodule

// File: rtl/memory_cycle.sv
// memory_cycle: MEM stage with SECDED data memory, single-cycle scrub FSM and MEM/WB registers.
// ECC_ERR_INJECT_EN adds inj_en/inj_mask so a store can write a deliberately corrupted codeword.
module memory_cycle
  import riscv_ecc_pkg::*;
#(
  parameter int DMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RdM,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
`ifdef ECC_ERR_INJECT_EN
  input  logic        inj_en,
  input  ecc_word_t   inj_mask,
`endif
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RdW,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        StallM,
  output logic        DbeW,
  output logic [15:0] SbeCount
);
  localparam int ADDR_W = $clog2(DMEM_DEPTH);

  mem_state_t state;
  ecc_word_t mem [DMEM_DEPTH];
  ecc_word_t stCode, rdWord, fixWord, scrubWord, wrWord;
  logic [ADDR_W-1:0] idx, scrubIdx, wrIdx;
  logic [DATA_W-1:0] fixData;
  logic sbe, dbe, scrub, isStore, isLoad, ldSbe, ldDbe, wrEn;
  logic [DATA_W-1:0] unusedStData;
  ecc_word_t unusedStWord, unusedLdCode;
  logic unusedStSbe, unusedStDbe;

  assign idx = ALU_ResultM[ADDR_W+1:2];
  assign rdWord = mem[idx];
  assign scrub = state == SCRUB;
  assign StallM = scrub;
  assign isStore = !scrub && MemWriteM;
  assign isLoad = !scrub && MemReadM && !MemWriteM;
  assign ldSbe = isLoad && sbe;
  assign ldDbe = isLoad && dbe;
  assign wrEn = rst && (scrub || isStore);
  assign wrIdx = scrub ? scrubIdx : idx;
`ifdef ECC_ERR_INJECT_EN
  assign wrWord = scrub ? scrubWord : stCode ^ (inj_en ? inj_mask : '0);
`else
  assign wrWord = scrub ? scrubWord : stCode;
`endif

  secded_codec u_store (
    .data(WriteDataM), .word('0), .code(stCode), .fixData(unusedStData),
    .fixWord(unusedStWord), .sbe(unusedStSbe), .dbe(unusedStDbe)
  );

  secded_codec u_load (
    .data('0), .word(rdWord), .code(unusedLdCode), .fixData(fixData),
    .fixWord(fixWord), .sbe(sbe), .dbe(dbe)
  );

  always_ff @(posedge clk)
    if (wrEn) mem[wrIdx] <= wrWord;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      RegWriteW <= 1'b0;
      ResultSrcW <= 1'b0;
      RdW <= '0;
      PCPlus4W <= '0;
      ALU_ResultW <= '0;
      ReadDataW <= '0;
      DbeW <= 1'b0;
      SbeCount <= '0;
      scrubIdx <= '0;
      scrubWord <= '0;
    end else if (scrub) begin
      state <= IDLE;
      RegWriteW <= 1'b0;
      ResultSrcW <= 1'b0;
      RdW <= '0;
      PCPlus4W <= '0;
      ALU_ResultW <= '0;
      ReadDataW <= '0;
      DbeW <= 1'b0;
    end else begin
      RegWriteW <= RegWriteM && !ldDbe;
      ResultSrcW <= ResultSrcM;
      RdW <= RdM;
      PCPlus4W <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW <= isLoad ? fixData : '0;
      DbeW <= ldDbe;
      if (ldSbe) begin
        SbeCount <= SbeCount + {15'b0, ~&SbeCount};
        scrubIdx <= idx;
        scrubWord <= fixWord;
        state <= SCRUB;
      end
    end
endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: directed bench for memory_cycle; bit errors are planted straight into the array.
module tb_memory_cycle;
  logic clk = 1'b0;
  logic rst;
  logic RegWriteM, MemWriteM, MemReadM, ResultSrcM;
  logic [4:0] RdM;
  logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
  logic RegWriteW, ResultSrcW, StallM, DbeW;
  logic [4:0] RdW;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
  logic [15:0] SbeCount;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  memory_cycle #(.DMEM_DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .MemReadM(MemReadM), .ResultSrcM(ResultSrcM), .RdM(RdM), .PCPlus4M(PCPlus4M),
    .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
`ifdef ECC_ERR_INJECT_EN
    .inj_en(1'b0), .inj_mask('0),
`endif
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW), .PCPlus4W(PCPlus4W),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .StallM(StallM), .DbeW(DbeW),
    .SbeCount(SbeCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic w, input logic r, input logic rw, input logic [31:0] a, input logic [31:0] d);
    MemWriteM = w;
    MemReadM = r;
    RegWriteM = rw;
    ResultSrcM = r;
    RdM = 5'd7;
    ALU_ResultM = a;
    PCPlus4M = a + 32'd4;
    WriteDataM = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Codeword bit 10 holds data bit 5, bit 3 holds data bit 0, bit 1 is a check bit, bit 0 overall parity.
  task automatic flip(input int i, input logic [38:0] m);
    dut.mem[i] = dut.mem[i] ^ m;
  endtask

  initial begin
    rst = 1'b0;
    {RegWriteM, MemWriteM, MemReadM, ResultSrcM} = '0;
    RdM = '0;
    PCPlus4M = '0;
    ALU_ResultM = '0;
    WriteDataM = '0;
    repeat (2) @(negedge clk);
    chk("rst_rd", ReadDataW, 0);
    chk("rst_rw", 32'(RegWriteW), 0);
    chk("rst_cnt", 32'(SbeCount), 0);
    chk("rst_stall", 32'(StallM), 0);
    chk("rst_dbe", 32'(DbeW), 0);
    rst = 1'b1;
    // T1 store then load
    op(1, 0, 0, 32'h40, 32'hDEADBEEF);
    op(0, 1, 1, 32'h40, 0);
    chk("t1_rd", ReadDataW, 32'hDEADBEEF);
    chk("t1_rw", 32'(RegWriteW), 1);
    chk("t1_stall", 32'(StallM), 0);
    chk("t1_cnt", 32'(SbeCount), 0);
    chk("t1_alu", ALU_ResultW, 32'h40);
    chk("t1_pc", PCPlus4W, 32'h44);
    chk("t1_rd_idx", 32'(RdW), 7);
    chk("t1_rsrc", 32'(ResultSrcW), 1);
    // T2 single data-bit error, scrub
    op(1, 0, 0, 32'h10, 32'h12345678);
    flip(4, 39'h400);
    op(0, 1, 1, 32'h10, 0);
    chk("t2_rd", ReadDataW, 32'h12345678);
    chk("t2_rw", 32'(RegWriteW), 1);
    chk("t2_cnt", 32'(SbeCount), 1);
    chk("t2_stall", 32'(StallM), 1);
    op(0, 1, 1, 32'h10, 0);
    chk("t2_bub_rw", 32'(RegWriteW), 0);
    chk("t2_bub_rd", ReadDataW, 0);
    chk("t2_bub_alu", ALU_ResultW, 0);
    chk("t2_stall_end", 32'(StallM), 0);
    op(0, 1, 1, 32'h10, 0);
    chk("t2_rd2", ReadDataW, 32'h12345678);
    chk("t2_cnt2", 32'(SbeCount), 1);
    chk("t2_stall2", 32'(StallM), 0);
    // T3 double error: raw data, no writeback, no scrub
    op(1, 0, 0, 32'h20, 32'hA5A5A5A5);
    flip(8, 39'h408);
    op(0, 1, 1, 32'h20, 0);
    chk("t3_dbe", 32'(DbeW), 1);
    chk("t3_rw", 32'(RegWriteW), 0);
    chk("t3_rd", ReadDataW, 32'hA5A5A584);
    chk("t3_cnt", 32'(SbeCount), 1);
    chk("t3_stall", 32'(StallM), 0);
    op(0, 0, 1, 32'h20, 0);
    chk("t3_alu_dbe", 32'(DbeW), 0);
    chk("t3_alu_rd", ReadDataW, 0);
    chk("t3_alu_rw", 32'(RegWriteW), 1);
    chk("t3_alu_stall", 32'(StallM), 0);
    // store+load together: store wins, old DBE word not flagged
    op(1, 1, 1, 32'h20, 32'h11112222);
    chk("both_dbe", 32'(DbeW), 0);
    chk("both_rw", 32'(RegWriteW), 1);
    chk("both_rd", ReadDataW, 0);
    op(0, 1, 1, 32'h20, 0);
    chk("both_ld", ReadDataW, 32'h11112222);
    // T4 address wrap and ignored low bits
    op(1, 0, 0, 32'h0, 32'h1);
    op(1, 0, 0, 32'h1000, 32'h2);
    op(0, 1, 1, 32'h0, 0);
    chk("t4_wrap", ReadDataW, 32'h2);
    op(0, 1, 1, 32'h3, 0);
    chk("t4_lowbits", ReadDataW, 32'h2);
    // T5 check-bit error, reset during scrub
    op(1, 0, 0, 32'h80, 32'hCAFEF00D);
    flip(32, 39'h2);
    op(0, 1, 1, 32'h80, 0);
    chk("t5_rd", ReadDataW, 32'hCAFEF00D);
    chk("t5_cnt", 32'(SbeCount), 2);
    chk("t5_stall", 32'(StallM), 1);
    rst = 1'b0;
    #1;
    chk("t5_rst_rd", ReadDataW, 0);
    chk("t5_rst_stall", 32'(StallM), 0);
    chk("t5_rst_cnt", 32'(SbeCount), 0);
    @(negedge clk);
    rst = 1'b1;
    op(0, 1, 1, 32'h80, 0);
    chk("t5_re_rd", ReadDataW, 32'hCAFEF00D);
    chk("t5_re_cnt", 32'(SbeCount), 1);
    chk("t5_re_stall", 32'(StallM), 1);
    op(0, 1, 1, 32'h80, 0);
    op(0, 1, 1, 32'h80, 0);
    chk("t5_clean_stall", 32'(StallM), 0);
    chk("t5_clean_cnt", 32'(SbeCount), 1);
    // T6 saturation; first error sits in the overall parity bit
    op(1, 0, 0, 32'h100, 32'h0BADC0DE);
    flip(64, 39'h1);
    dut.SbeCount = 16'hFFFE;
    op(0, 1, 1, 32'h100, 0);
    chk("t6_rd", ReadDataW, 32'h0BADC0DE);
    chk("t6_cnt", 32'(SbeCount), 32'hFFFF);
    chk("t6_stall", 32'(StallM), 1);
    op(0, 1, 1, 32'h100, 0);
    flip(64, 39'h100000);
    op(0, 1, 1, 32'h100, 0);
    chk("t6_rd2", ReadDataW, 32'h0BADC0DE);
    chk("t6_sat", 32'(SbeCount), 32'hFFFF);
    chk("t6_stall2", 32'(StallM), 1);
    op(0, 0, 0, 32'h0, 0);
    op(0, 1, 1, 32'h100, 0);
    chk("t6_clean_stall", 32'(StallM), 0);
    chk("t6_clean_rd", ReadDataW, 32'h0BADC0DE);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
